// File: rtl/alu_multiword_seq_if.sv
// Request/response bundle between the control path and the multi-word ALU sequencer.
interface alu_multiword_seq_if #(
  parameter int N = 4,
  parameter int K = 4
);
  logic           req_valid;
  logic           req_ready;
  logic [3:0]     req_op;
  logic [N*K-1:0] req_a;
  logic [N*K-1:0] req_b;
  logic           req_cin;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [N*K-1:0] rsp_result;
  logic           rsp_z;
  logic           rsp_c;
  logic           rsp_err;

  // Sequencer side: accepts requests, produces responses.
  modport slave (
    input  req_valid, req_op, req_a, req_b, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_z, rsp_c, rsp_err
  );

  // Client side: issues requests, consumes responses.
  modport master (
    output req_valid, req_op, req_a, req_b, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_z, rsp_c, rsp_err
  );
endinterface

// File: rtl/alu_multiword_seq.sv
// Runs a W = N*K bit AND/OR/ADD/SUB on an external N-bit ALU slice, one slice
// per clock from the LSB up, chaining carry/borrow and accumulating the zero flag.
module alu_multiword_seq #(
  parameter int N = 4,
  parameter int K = 4
) (
  input  logic        clk,
  input  logic        rst,
  alu_multiword_seq_if.slave bus,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_ctrl,
  output logic         alu_cin,
  input  logic [N-1:0] alu_result,
  input  logic [1:0]   alu_flags
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(K - 1);

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    carry_q, carry_d;
  logic                    zacc_q, zacc_d;
  logic [3:0]              op_q, op_d;
  logic [K-1:0][N-1:0]     a_q, a_d;
  logic [K-1:0][N-1:0]     b_q, b_d;
  logic [K-1:0][N-1:0]     res_q, res_d;
  logic                    z_q, z_d;
  logic                    c_q, c_d;
  logic                    err_q, err_d;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0110: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  // Next-state logic: accept in IDLE, one slice per clock in RUN, hold in DONE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    zacc_d  = zacc_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    z_d     = z_q;
    c_d     = c_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          op_d    = bus.req_op;
          a_d     = bus.req_a;
          b_d     = bus.req_b;
          carry_d = bus.req_cin;
          zacc_d  = 1'b1;
          idx_d   = '0;
          if (op_legal(bus.req_op)) begin
            err_d   = 1'b0;
            state_d = S_RUN;
          end else begin
            // Illegal opcode short-circuits to a zeroed error response.
            err_d   = 1'b1;
            res_d   = '0;
            z_d     = 1'b0;
            c_d     = 1'b0;
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        res_d[idx_q] = alu_result;
        carry_d      = alu_flags[0];
        zacc_d       = zacc_q & alu_flags[1];
        idx_d        = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          z_d     = zacc_q & alu_flags[1];
          c_d     = alu_flags[0];
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      zacc_q  <= 1'b1;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      zacc_q  <= zacc_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      z_q     <= z_d;
      c_q     <= c_d;
      err_q   <= err_d;
    end
  end

  // ALU is only driven while slicing so it never sees spurious operations.
  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = '0;
    alu_cin  = 1'b0;
    if (state_q == S_RUN) begin
      alu_a    = a_q[idx_q];
      alu_b    = b_q[idx_q];
      alu_ctrl = op_q;
      alu_cin  = carry_q;
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.rsp_valid  = (state_q == S_DONE);
  assign bus.rsp_result = res_q;
  assign bus.rsp_z      = z_q;
  assign bus.rsp_c      = c_q;
  assign bus.rsp_err    = err_q;

endmodule

// File: tb/tb_alu_multiword_seq.sv
// Directed bench for alu_multiword_seq with a behavioural N-bit ALU slice and
// a scoreboard of full-width expected results.
module tb_alu_multiword_seq;
  localparam int N = 4;
  localparam int K = 4;
  localparam int W = N * K;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] alu_a, alu_b, alu_result;
  logic [3:0]   alu_ctrl;
  logic         alu_cin;
  logic [1:0]   alu_flags;
  logic [N:0]   alu_t;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [W-1:0] res;
    logic         z;
    logic         c;
    logic         err;
  } exp_t;

  exp_t sb[$];

  alu_multiword_seq_if #(.N(N), .K(K)) bus ();

  alu_multiword_seq #(.N(N), .K(K)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_cin    (alu_cin),
    .alu_result (alu_result),
    .alu_flags  (alu_flags)
  );

  always #5 clk = ~clk;

  // Behavioural single-slice ALU: flags are {Z, C}; SUB borrow is bit N.
  always_comb begin
    alu_t = '0;
    case (alu_ctrl)
      4'b0000: alu_t = {alu_cin, alu_a & alu_b};
      4'b0001: alu_t = {alu_cin, alu_a | alu_b};
      4'b0010: alu_t = {1'b0, alu_a} + {1'b0, alu_b} + {{N{1'b0}}, alu_cin};
      4'b0110: alu_t = {1'b0, alu_a} - {1'b0, alu_b} - {{N{1'b0}}, alu_cin};
      default: alu_t = '0;
    endcase
    alu_result = alu_t[N-1:0];
    alu_flags  = {(alu_t[N-1:0] == '0), alu_t[N]};
  end

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic cin);
    exp_t e;
    logic [W:0] t;
    t = '0;
    e = '0;
    case (op)
      4'b0000: t = {cin, a & b};
      4'b0001: t = {cin, a | b};
      4'b0010: t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      4'b0110: t = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin};
      default: begin
        e.err = 1'b1;
        return e;
      end
    endcase
    e.res = t[W-1:0];
    e.z   = (t[W-1:0] == '0);
    e.c   = t[W];
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_idle_reset(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_result"},    32'(bus.rsp_result), 32'd0);
    chk({tag, "_zce"},       32'({bus.rsp_z, bus.rsp_c, bus.rsp_err}), 32'd0);
    chk({tag, "_alu"},       32'({alu_a, alu_b, alu_ctrl, alu_cin}), 32'd0);
  endtask

  // Issue one request, wait for its response, optionally stall the consumer.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic cin, input int hold);
    exp_t e;
    exp_t ref_e;
    int   cnt;
    bit   got;
    ref_e = model(op, a, b, cin);
    @(negedge clk);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_cin   = cin;
    bus.req_valid = 1'b1;
    sb.push_back(ref_e);
    cnt = 0;
    got = 1'b0;
    while (!got && cnt < 30) begin
      @(posedge clk);
      #1;
      cnt++;
      if (cnt == 1) begin
        bus.req_valid = 1'b0;
        if (!ref_e.err) chk({tag, "_alu_ctrl_run"}, 32'(alu_ctrl), 32'(op));
      end
      if (bus.rsp_valid) got = 1'b1;
      else chk({tag, "_req_ready_busy"}, 32'(bus.req_ready), 32'd0);
    end
    e = sb.pop_front();
    if (!got) begin
      chk({tag, "_timeout"}, 32'(got), 32'd1);
      return;
    end
    chk({tag, "_latency"}, 32'(cnt), e.err ? 32'd1 : 32'(K + 1));
    chk({tag, "_result"},  32'(bus.rsp_result), 32'(e.res));
    chk({tag, "_z"},       32'(bus.rsp_z), 32'(e.z));
    chk({tag, "_c"},       32'(bus.rsp_c), 32'(e.c));
    chk({tag, "_err"},     32'(bus.rsp_err), 32'(e.err));
    if (e.err) chk({tag, "_alu_ctrl_done"}, 32'(alu_ctrl), 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_op    = 4'b0010;
      bus.req_a     = W'($urandom);
      bus.req_b     = W'($urandom);
      @(posedge clk);
      #1;
      chk({tag, "_hold_valid"},  32'(bus.rsp_valid), 32'd1);
      chk({tag, "_hold_result"}, 32'(bus.rsp_result), 32'(e.res));
      chk({tag, "_hold_flags"},  32'({bus.rsp_z, bus.rsp_c, bus.rsp_err}), 32'({e.z, e.c, e.err}));
      chk({tag, "_hold_ready"},  32'(bus.req_ready), 32'd0);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_release_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_release_ready"}, 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cin   = 1'b0;
    bus.rsp_ready = 1'b0;
    #2;
    chk_idle_reset("por");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op("add_wrap",  4'b0010, 16'hFFFF, 16'h0001, 1'b0, 0);
    run_op("sub_borrow", 4'b0110, 16'h0000, 16'h0001, 1'b0, 0);
    run_op("sub_noborrow", 4'b0110, 16'h1000, 16'h0001, 1'b0, 0);
    run_op("sub_cin",   4'b0110, 16'h0005, 16'h0003, 1'b1, 0);
    run_op("and_cin1",  4'b0000, 16'hF0F0, 16'h0F0F, 1'b1, 0);
    run_op("or_all",    4'b0001, 16'hF0F0, 16'h0F0F, 1'b0, 0);
    run_op("add_hold",  4'b0010, 16'h1234, 16'h4321, 1'b1, 3);

    // Reset in the middle of RUN, with slice index 2 presented to the ALU.
    @(negedge clk);
    bus.req_op    = 4'b0010;
    bus.req_a     = 16'hFFFF;
    bus.req_b     = 16'h1234;
    bus.req_cin   = 1'b0;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("midrun_alu_a_idx2", 32'(alu_a), 32'hF);
    chk("midrun_alu_b_idx2", 32'(alu_b), 32'h2);
    rst = 1'b1;
    #1;
    chk_idle_reset("midrun_rst");
    @(negedge clk);
    rst = 1'b0;

    run_op("add_after_rst", 4'b0010, 16'h0001, 16'h0001, 1'b0, 0);
    run_op("illegal",       4'b0101, 16'hABCD, 16'h1234, 1'b1, 0);

    for (int i = 0; i < 4; i++) begin
      run_op("rand_add", 4'b0010, W'($urandom), W'($urandom), 1'($urandom), 0);
      run_op("rand_sub", 4'b0110, W'($urandom), W'($urandom), 1'($urandom), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
